mppt_state_bank: RTL and testbench

Parametrised multi-channel state/flag register for the MPPT controller cores. It holds the registered state and flags of N independent tracking FSMs, one per panel string. Per channel it also provides a load enable, a synchronous clear, the previous state, a state-change pulse and a dwell counter. A watchdog forces a channel back to its initial state if its FSM stalls. It sits between each channel's next-state logic and the rest of the tracker.

---
 rtl/mppt_state_bank.sv | 149 ++++++++++++++
 tb/tb_mppt_state_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mppt_state_bank.sv
// mppt_state_bank
// -----------------------------------------------------------------------------
// Multi-channel state/flag register bank for the MPPT tracking FSMs, one
// channel per panel string. Each channel registers its FSM state and flags,
// remembers the state held before the last change, pulses chg after a change,
// counts falling edges since the last change (dwell) and runs a stall watchdog
// that forces the channel back to INIT_STATE.
//
// All storage updates on the FALLING edge of clk; rst is synchronous and
// active-high and is sampled on that same edge.
//
// Ports
//   clk         clock (storage updates on falling edge)
//   rst         synchronous active-high reset, all channels
//   ld[N]       per-channel load enable
//   clr[N]      per-channel synchronous clear
//   nstate      next state, channel i at [i*SW +: SW]
//   flag_i      flag inputs, channel i at [i*FW +: FW]
//   state       current state
//   prev_state  state held before the last change
//   flag_o      registered flags
//   chg[N]      one-cycle pulse after a state change
//   dwell       saturating edges-since-last-change, channel i at [i*DW +: DW]
//   wdt[N]      sticky watchdog-expired indication
// -----------------------------------------------------------------------------

// Per-channel slice. Instantiated N times by mppt_state_bank.
//   Inputs : clk, rst, ld, clr, nstate[SW], flag_i[FW]
//   Outputs: state[SW], prev_state[SW], flag_o[FW], chg, dwell[DW], wdt
module mppt_state_chan #(
    parameter int SW          = 3,
    parameter int FW          = 2,
    parameter int DW          = 8,
    parameter int TIMEOUT     = 200,
    parameter int INIT_STATE  = 0,
    parameter int FLAG_STICKY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          clr,
    input  logic [SW-1:0] nstate,
    input  logic [FW-1:0] flag_i,
    output logic [SW-1:0] state,
    output logic [SW-1:0] prev_state,
    output logic [FW-1:0] flag_o,
    output logic          chg,
    output logic [DW-1:0] dwell,
    output logic          wdt
);
    localparam logic [SW-1:0] INIT     = SW'(INIT_STATE);
    localparam logic [DW-1:0] TO       = DW'(TIMEOUT);
    localparam logic [DW-1:0] DWELL_MX = '1;
    localparam bit            WDT_ON   = (TIMEOUT != 0);
    localparam bit            STICKY   = (FLAG_STICKY != 0);

    logic          change;
    logic          expire;
    logic [DW-1:0] dwell_inc;
    logic [FW-1:0] flag_nxt;

    // A real transition is the only thing that counts as progress; a load of
    // the same state does not rescue a stalled channel from the watchdog.
    assign change    = ld && (nstate != state);
    assign expire    = WDT_ON && (dwell == TO) && !change;

    // Counter sticks at all-ones instead of wrapping.
    assign dwell_inc = (dwell == DWELL_MX) ? dwell : dwell + 1'b1;

    assign flag_nxt  = STICKY ? (flag_o | flag_i) : flag_i;

    always_ff @(negedge clk) begin
        if (rst || clr) begin
            state      <= INIT;
            prev_state <= INIT;
            flag_o     <= '0;
            chg        <= 1'b0;
            dwell      <= '0;
            wdt        <= 1'b0;
        end else if (expire) begin
            // Forced return to INIT. Flags and ld are ignored on this edge;
            // chg only fires if the state actually moves.
            state      <= INIT;
            prev_state <= state;
            chg        <= (state != INIT);
            dwell      <= '0;
            wdt        <= 1'b1;
        end else if (change) begin
            state      <= nstate;
            prev_state <= state;
            flag_o     <= flag_nxt;
            chg        <= 1'b1;
            dwell      <= '0;
        end else begin
            // Same-state load still refreshes flags; plain hold does not.
            if (ld) flag_o <= flag_nxt;
            chg        <= 1'b0;
            dwell      <= dwell_inc;
        end
    end
endmodule

module mppt_state_bank #(
    parameter int N           = 2,
    parameter int SW          = 3,
    parameter int FW          = 2,
    parameter int DW          = 8,
    parameter int TIMEOUT     = 200,
    parameter int INIT_STATE  = 0,
    parameter int FLAG_STICKY = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    ld,
    input  logic [N-1:0]    clr,
    input  logic [N*SW-1:0] nstate,
    input  logic [N*FW-1:0] flag_i,
    output logic [N*SW-1:0] state,
    output logic [N*SW-1:0] prev_state,
    output logic [N*FW-1:0] flag_o,
    output logic [N-1:0]    chg,
    output logic [N*DW-1:0] dwell,
    output logic [N-1:0]    wdt
);
    // Channels share nothing but clk and rst.
    for (genvar i = 0; i < N; i++) begin : g_ch
        mppt_state_chan #(
            .SW          (SW),
            .FW          (FW),
            .DW          (DW),
            .TIMEOUT     (TIMEOUT),
            .INIT_STATE  (INIT_STATE),
            .FLAG_STICKY (FLAG_STICKY)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .ld         (ld[i]),
            .clr        (clr[i]),
            .nstate     (nstate[i*SW +: SW]),
            .flag_i     (flag_i[i*FW +: FW]),
            .state      (state[i*SW +: SW]),
            .prev_state (prev_state[i*SW +: SW]),
            .flag_o     (flag_o[i*FW +: FW]),
            .chg        (chg[i]),
            .dwell      (dwell[i*DW +: DW]),
            .wdt        (wdt[i])
        );
    end
endmodule

// File: tb/tb_mppt_state_bank.sv
// Bench for mppt_state_bank. Two instances share one stimulus stream:
//   A: DW=8, TIMEOUT=10, FLAG_STICKY=0
//   B: DW=4, TIMEOUT=0 (no watchdog), FLAG_STICKY=1
// The driver applies inputs after each rising edge, advances a per-channel
// reference model and queues the expected outputs; the monitor pops one entry
// on each following rising edge (after the DUT's falling-edge update).
module tb_mppt_state_bank;
    localparam int N  = 2;
    localparam int SW = 3;
    localparam int FW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ld, clr;
    logic [N*SW-1:0] nstate;
    logic [N*FW-1:0] flag_i;

    logic [N*SW-1:0] a_state, a_prev, b_state, b_prev;
    logic [N*FW-1:0] a_flag, b_flag;
    logic [N-1:0]    a_chg, a_wdt, b_chg, b_wdt;
    logic [N*8-1:0]  a_dwell;
    logic [N*4-1:0]  b_dwell;
    logic [N*8-1:0]  b_dw8;

    assign b_dw8 = {4'b0, b_dwell[7:4], 4'b0, b_dwell[3:0]};

    always #5 clk = ~clk;

    mppt_state_bank #(.N(N), .SW(SW), .FW(FW), .DW(8), .TIMEOUT(10),
                      .INIT_STATE(0), .FLAG_STICKY(0)) dut_a (
        .clk(clk), .rst(rst), .ld(ld), .clr(clr), .nstate(nstate), .flag_i(flag_i),
        .state(a_state), .prev_state(a_prev), .flag_o(a_flag), .chg(a_chg),
        .dwell(a_dwell), .wdt(a_wdt));

    mppt_state_bank #(.N(N), .SW(SW), .FW(FW), .DW(4), .TIMEOUT(0),
                      .INIT_STATE(0), .FLAG_STICKY(1)) dut_b (
        .clk(clk), .rst(rst), .ld(ld), .clr(clr), .nstate(nstate), .flag_i(flag_i),
        .state(b_state), .prev_state(b_prev), .flag_o(b_flag), .chg(b_chg),
        .dwell(b_dwell), .wdt(b_wdt));

    // Reference model: plain integers per config/channel.
    int c_to[2]     = '{10, 0};
    int c_max[2]    = '{255, 15};
    int c_sticky[2] = '{0, 1};
    int m_st[2][N], m_pv[2][N], m_fl[2][N], m_dw[2][N], m_chg[2][N], m_wdt[2][N];

    typedef struct packed {
        logic [N*SW-1:0] st, pv;
        logic [N*FW-1:0] fl;
        logic [N-1:0]    chg, wdt;
        logic [N*8-1:0]  dw;
    } snap_t;

    snap_t qa[$], qb[$];
    int total = 0;
    int bad   = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected snapshot per falling edge, checked at the next rising edge.
    initial begin
        snap_t ea, eb;
        forever begin
            @(posedge clk);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                cmp("a.state", 64'(a_state), 64'(ea.st));
                cmp("a.prev",  64'(a_prev),  64'(ea.pv));
                cmp("a.flag",  64'(a_flag),  64'(ea.fl));
                cmp("a.chg",   64'(a_chg),   64'(ea.chg));
                cmp("a.dwell", 64'(a_dwell), 64'(ea.dw));
                cmp("a.wdt",   64'(a_wdt),   64'(ea.wdt));
                cmp("b.state", 64'(b_state), 64'(eb.st));
                cmp("b.prev",  64'(b_prev),  64'(eb.pv));
                cmp("b.flag",  64'(b_flag),  64'(eb.fl));
                cmp("b.chg",   64'(b_chg),   64'(eb.chg));
                cmp("b.dwell", 64'(b_dw8),   64'(eb.dw));
                cmp("b.wdt",   64'(b_wdt),   64'(eb.wdt));
            end
        end
    end

    // Apply one edge's worth of inputs and queue what each DUT must show after it.
    task automatic step(input bit r, input bit [1:0] l, input bit [1:0] c,
                        input int ns0, input int ns1, input int f0, input int f1);
        int    ns[N];
        int    fi[N];
        snap_t s;
        @(posedge clk);
        #1;
        ns[0] = ns0 % 8; ns[1] = ns1 % 8;
        fi[0] = f0 % 4;  fi[1] = f1 % 4;
        rst    = r;
        ld     = l;
        clr    = c;
        nstate = {SW'(ns[1]), SW'(ns[0])};
        flag_i = {FW'(fi[1]), FW'(fi[0])};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                bit moved;
                moved = l[i] && (ns[i] != m_st[k][i]);
                if (r || c[i]) begin
                    m_st[k][i] = 0; m_pv[k][i] = 0; m_fl[k][i] = 0;
                    m_dw[k][i] = 0; m_chg[k][i] = 0; m_wdt[k][i] = 0;
                end else if (c_to[k] != 0 && m_dw[k][i] == c_to[k] && !moved) begin
                    m_chg[k][i] = (m_st[k][i] != 0) ? 1 : 0;
                    m_pv[k][i]  = m_st[k][i];
                    m_st[k][i]  = 0;
                    m_dw[k][i]  = 0;
                    m_wdt[k][i] = 1;
                end else begin
                    if (l[i]) m_fl[k][i] = c_sticky[k] ? (m_fl[k][i] | fi[i]) : fi[i];
                    if (moved) begin
                        m_pv[k][i]  = m_st[k][i];
                        m_st[k][i]  = ns[i];
                        m_dw[k][i]  = 0;
                        m_chg[k][i] = 1;
                    end else begin
                        m_dw[k][i]  = (m_dw[k][i] + 1 > c_max[k]) ? c_max[k] : m_dw[k][i] + 1;
                        m_chg[k][i] = 0;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                s.st[i*SW +: SW] = SW'(m_st[k][i]);
                s.pv[i*SW +: SW] = SW'(m_pv[k][i]);
                s.fl[i*FW +: FW] = FW'(m_fl[k][i]);
                s.chg[i]         = m_chg[k][i][0];
                s.wdt[i]         = m_wdt[k][i][0];
                s.dw[i*8 +: 8]   = 8'(m_dw[k][i]);
            end
            if (k == 0) qa.push_back(s);
            else        qb.push_back(s);
        end
    endtask

    task automatic hold(input int n);
        for (int j = 0; j < n; j++) step(0, 2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; ld = '0; clr = '0; nstate = '0; flag_i = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                m_st[k][i] = 0; m_pv[k][i] = 0; m_fl[k][i] = 0;
                m_dw[k][i] = 0; m_chg[k][i] = 0; m_wdt[k][i] = 0;
            end

        // Reset and first load of ch0
        step(1, 2'b00, 2'b00, 0, 0, 0, 0);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0);
        step(0, 2'b01, 2'b00, 3, 0, 2, 0);
        hold(2);
        // Same-state loads: no chg, dwell keeps counting, sticky flags accumulate
        step(0, 2'b01, 2'b00, 3, 0, 1, 0);
        step(0, 2'b01, 2'b00, 3, 0, 2, 0);
        // Watchdog: ch0 to 5, stall until expiry, then clear
        step(0, 2'b01, 2'b00, 5, 0, 0, 0);
        hold(14);
        step(0, 2'b00, 2'b01, 0, 0, 0, 0);
        hold(1);
        // Progress at dwell==TIMEOUT beats expiry
        step(0, 2'b01, 2'b00, 5, 0, 0, 0);
        hold(10);
        step(0, 2'b01, 2'b00, 6, 0, 0, 0);
        // Same-state load at dwell==TIMEOUT loses to expiry
        hold(10);
        step(0, 2'b01, 2'b00, 6, 0, 3, 0);
        hold(1);
        // Clear ch1 while ch0 loads; then rst together with ld
        step(0, 2'b10, 2'b00, 0, 4, 0, 3);
        hold(2);
        step(0, 2'b01, 2'b10, 2, 7, 1, 2);
        step(0, 2'b11, 2'b00, 1, 1, 3, 3);
        step(1, 2'b11, 2'b00, 4, 5, 3, 3);
        // Saturation of the narrow counter
        hold(20);

        // Randomized traffic; same-state loads are frequent so stalls occur
        for (int j = 0; j < 1500; j++) begin
            bit [1:0] l, c;
            bit       r;
            int       n0, n1;
            r    = ($urandom_range(0, 199) == 0);
            l[0] = ($urandom_range(0, 5) == 0);
            l[1] = ($urandom_range(0, 5) == 0);
            c[0] = ($urandom_range(0, 63) == 0);
            c[1] = ($urandom_range(0, 63) == 0);
            n0   = $urandom_range(0, 1) ? m_st[0][0] : int'($urandom_range(0, 7));
            n1   = $urandom_range(0, 1) ? m_st[0][1] : int'($urandom_range(0, 7));
            step(r, l, c, n0, n1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", qa.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
